mandel_raster_engine: RTL and testbench
=======================================

# mandel_raster_engine

Computes the Mandelbrot escape-iteration count for every pixel of an H_RES × V_RES frame. It walks the frame in raster order, maps each count to a 24-bit colour, and writes it through the VRAM write port. It is the producer for the frame buffer that the VGA display stage scans out. A frame is triggered by a one-cycle `start` pulse carrying the viewport origin and per-pixel step.

## Interface
- `WIDTH`, 32: signed fixed-point word width for c and z.
- `FRAC`, 28: fractional bits (Q4.28).
- `MAX_ITER`, 255: iteration cap, ≤ 255.
- `H_RES`, 800: pixels per row.
- `V_RES`, 600: rows per frame.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle frame request; accepted only in IDLE.
- `re_origin` in WIDTH: real part of pixel (0,0); sampled on accepted `start`.
- `im_origin` in WIDTH: imaginary part of pixel (0,0); sampled on accepted `start`.
- `step` in WIDTH: positive per-pixel increment; sampled on accepted `start`.
- `busy` out 1: high in ITERATE and WRITE.
- `done` out 1: one-cycle pulse after the last pixel's write.
- `vram_wr_en` out 1: write strobe.
- `vram_wr_row` out 10: target row.
- `vram_wr_col` out 10: target column.
- `vram_wr_data` out 24: pixel colour as {R[7:0], G[7:0], B[7:0]}.

## Operation
- FSM states are IDLE, ITERATE, WRITE, DONE.
- **IDLE:**
  - On `start`, latch the origin and step.
  - Set row = col = 0, cr = re_origin, ci = im_origin, zr = zi = 0, iter = 0.
  - Go to ITERATE.
- **ITERATE, one cycle per step:**
  - Form the full 2·WIDTH products zr·zr, zi·zi and zr·zi, then arithmetic-shift each right by FRAC to get zr2, zi2 and zrzi.
  - Escape test: zr2 + zi2 > 4.0, i.e. 4 << FRAC. The sum is evaluated at WIDTH+2 bits so it cannot wrap.
  - If the test escapes or iter == MAX_ITER, go to WRITE with z and iter unchanged.
  - Otherwise update zr ← zr2 − zi2 + cr, zi ← 2·zrzi + ci and iter ← iter + 1, all truncated to WIDTH.
- **WRITE, exactly one cycle:**
  - Assert `vram_wr_en` with the current row and col.
  - Data is 24'h000000 if iter == MAX_ITER, else {iter[7:0], iter[6:0],1'b0, iter[5:0],2'b00}.
  - In the same cycle, reset z and iter and advance the position:
    - If col < H_RES−1: col++, cr += step.
    - Else: col = 0, cr = re_origin, row++, ci −= step (imaginary decreases downward).
  - If the write was for (V_RES−1, H_RES−1), go to DONE; otherwise go to ITERATE.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- `start` is ignored outside IDLE and does not affect the frame in progress.
- `vram_wr_row`, `vram_wr_col` and `vram_wr_data` are valid only while `vram_wr_en` = 1. They hold their values otherwise.

## Timing
- **Reset:**
  - State returns to IDLE.
  - `busy`, `done` and `vram_wr_en` go to 0.
  - `vram_wr_row`, `vram_wr_col` and `vram_wr_data` go to 0.
  - All internal registers clear.
- **Reset mid-frame:** the FSM goes to IDLE immediately. No further writes occur and the partial frame stays in VRAM.
- **Per-pixel cost:** n+1 ITERATE cycles plus 1 WRITE cycle, where n is the number of iterations performed (0 ≤ n ≤ MAX_ITER).
- `busy` rises the cycle after an accepted `start` and falls in the DONE cycle.
- `done` is asserted in the cycle after the final write.
- The VRAM write is single-cycle with no backpressure. The downstream memory must accept one write per clock.

## Structure
- A shared package holds:
  - the fixed-point format constants (WIDTH, FRAC, the 4.0 threshold);
  - the FSM state encoding;
  - the colour-map function.
- Natural sub-module: `mandel_iter_core`.
  - Combinational.
  - Inputs: zr, zi, cr, ci.
  - Outputs: the next zr and zi, plus `escaped`.
  - The FSM and raster counters remain in the top level.

## Test plan
- c = 0 (origin 0, step = 1, H_RES = 1, V_RES = 1) → one write at (0,0) with data 24'h000000, after MAX_ITER+2 cycles; `done` pulses on the next cycle.
- re_origin = 2.5, im_origin = 0 → first check on z = 0 passes, z becomes 2.5, second check 6.25 > 4 escapes with iter = 1 → data 24'h010204, 3 cycles per pixel.
- H_RES = 4, V_RES = 3, step = 0.25 → 12 writes in raster order:
  - (0,3) is followed by (1,0), with cr reset to re_origin and ci reduced by step.
  - `done` follows the (2,3) write.
- `start` pulsed mid-frame with a different origin → no restart, all write values unchanged.
- `reset_n` low during ITERATE of pixel 5 → outputs all 0 immediately with no further writes; a new `start` then restarts at (0,0).

Source files
------------

// File: rtl/mandel_raster_engine_pkg.sv
// Shared fixed-point format, FSM encoding and colour map for the Mandelbrot raster engine.
package mandel_raster_engine_pkg;

  localparam int unsigned FP_WIDTH = 32;
  localparam int unsigned FP_FRAC  = 28;
  localparam int unsigned ITER_W   = 8;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOUR_W = 24;

  // Escape threshold 4.0 in the Q4.28 format, held with two guard bits.
  localparam int unsigned        ESC_W         = FP_WIDTH + 2;
  localparam logic [ESC_W-1:0]   ESC_THRESHOLD = ESC_W'(4) << FP_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITERATE,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Pixels that never escaped are black; escaped pixels get a ramp that
  // runs at 1x, 2x and 4x speed on the R, G and B channels.
  function automatic logic [COLOUR_W-1:0] colour_map(input logic [ITER_W-1:0] iter,
                                                     input logic [ITER_W-1:0] max_iter);
    if (iter == max_iter) return '0;
    return {iter, iter[6:0], 1'b0, iter[5:0], 2'b00};
  endfunction

endpackage

// File: rtl/mandel_raster_engine_iter_core.sv
// One combinational Mandelbrot step: z' = z^2 + c, plus the |z|^2 > 4 escape test on the current z.
module mandel_iter_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 28
) (
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] zr_next,
  output logic signed [WIDTH-1:0] zi_next,
  output logic                    escaped
);

  localparam int unsigned PW = 2 * WIDTH;
  // Full-product width: the escape sum cannot wrap for any representable z.
  localparam logic signed [PW-1:0] THRESHOLD = PW'(4) << FRAC;

  logic signed [PW-1:0] zr_x, zi_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ri;
  logic signed [PW-1:0] zr2, zi2, zrzi;
  logic signed [PW-1:0] mag;

  assign zr_x = PW'(zr);
  assign zi_x = PW'(zi);

  assign p_rr = zr_x * zr_x;
  assign p_ii = zi_x * zi_x;
  assign p_ri = zr_x * zi_x;

  assign zr2  = p_rr >>> FRAC;
  assign zi2  = p_ii >>> FRAC;
  assign zrzi = p_ri >>> FRAC;

  assign mag     = zr2 + zi2;
  assign escaped = mag > THRESHOLD;

  assign zr_next = WIDTH'(zr2 - zi2) + cr;
  assign zi_next = (WIDTH'(zrzi) <<< 1) + ci;

endmodule

// File: rtl/mandel_raster_engine.sv
// Walks an H_RES x V_RES frame in raster order, iterating each pixel and writing its colour to VRAM.
module mandel_raster_engine
  import mandel_raster_engine_pkg::*;
#(
  parameter int unsigned WIDTH    = FP_WIDTH,
  parameter int unsigned FRAC     = FP_FRAC,
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned H_RES    = 800,
  parameter int unsigned V_RES    = 600
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] re_origin,
  input  logic [WIDTH-1:0] im_origin,
  input  logic [WIDTH-1:0] step,
  output logic             busy,
  output logic             done,
  output logic             vram_wr_en,
  output logic [9:0]       vram_wr_row,
  output logic [9:0]       vram_wr_col,
  output logic [23:0]      vram_wr_data
);

  localparam logic [ITER_W-1:0]  MAX_ITER_W = ITER_W'(MAX_ITER);
  localparam logic [COORD_W-1:0] COL_LAST   = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] ROW_LAST   = COORD_W'(V_RES - 1);

  state_t                    state;
  logic signed [WIDTH-1:0]   re0, step_r;
  logic signed [WIDTH-1:0]   cr, ci, zr, zi;
  logic signed [WIDTH-1:0]   zr_next, zi_next;
  logic                      escaped;
  logic [ITER_W-1:0]         iter;
  logic [COORD_W-1:0]        row, col;

  mandel_iter_core #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_iter_core (
    .zr      (zr),
    .zi      (zi),
    .cr      (cr),
    .ci      (ci),
    .zr_next (zr_next),
    .zi_next (zi_next),
    .escaped (escaped)
  );

  // Frame FSM, raster counters and registered VRAM write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      re0          <= '0;
      step_r       <= '0;
      cr           <= '0;
      ci           <= '0;
      zr           <= '0;
      zi           <= '0;
      iter         <= '0;
      row          <= '0;
      col          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vram_wr_en   <= 1'b0;
      vram_wr_row  <= '0;
      vram_wr_col  <= '0;
      vram_wr_data <= '0;
    end else begin
      done       <= 1'b0;
      vram_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            re0    <= re_origin;
            step_r <= step;
            cr     <= re_origin;
            ci     <= im_origin;
            zr     <= '0;
            zi     <= '0;
            iter   <= '0;
            row    <= '0;
            col    <= '0;
            busy   <= 1'b1;
            state  <= ST_ITERATE;
          end
        end
        ST_ITERATE: begin
          if (escaped || iter == MAX_ITER_W) begin
            vram_wr_en   <= 1'b1;
            vram_wr_row  <= row;
            vram_wr_col  <= col;
            vram_wr_data <= colour_map(iter, MAX_ITER_W);
            state        <= ST_WRITE;
          end else begin
            zr   <= zr_next;
            zi   <= zi_next;
            iter <= iter + ITER_W'(1);
          end
        end
        ST_WRITE: begin
          zr   <= '0;
          zi   <= '0;
          iter <= '0;
          // Imaginary axis decreases going down the frame.
          if (col == COL_LAST) begin
            col <= '0;
            cr  <= re0;
            row <= row + COORD_W'(1);
            ci  <= ci - step_r;
          end else begin
            col <= col + COORD_W'(1);
            cr  <= cr + step_r;
          end
          if (row == ROW_LAST && col == COL_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state <= ST_ITERATE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_raster_engine.sv
// Scoreboard bench for mandel_raster_engine on a 4x3 frame with hand-computed escape counts.
module tb_mandel_raster_engine;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int MAXI = 255;
  localparam int NPIX = H * V;

  localparam logic [31:0] FX_0_25 = 32'h0400_0000;
  localparam logic [31:0] FX_1_5  = 32'h1800_0000;
  localparam logic [31:0] FX_2_5  = 32'h2800_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] re_origin = '0;
  logic [31:0] im_origin = '0;
  logic [31:0] step = '0;
  logic        busy, done, vram_wr_en;
  logic [9:0]  vram_wr_row, vram_wr_col;
  logic [23:0] vram_wr_data;

  always #5 clock = ~clock;

  mandel_raster_engine #(
    .WIDTH    (32),
    .FRAC     (28),
    .MAX_ITER (MAXI),
    .H_RES    (H),
    .V_RES    (V)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .re_origin    (re_origin),
    .im_origin    (im_origin),
    .step         (step),
    .busy         (busy),
    .done         (done),
    .vram_wr_en   (vram_wr_en),
    .vram_wr_row  (vram_wr_row),
    .vram_wr_col  (vram_wr_col),
    .vram_wr_data (vram_wr_data)
  );

  typedef struct {
    int          row;
    int          col;
    logic [23:0] data;
    int          gap;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   wr_seen = 0;

  int n_zero[NPIX];
  int n_one[NPIX];
  int n_mix[NPIX];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] colour_of(input int n);
    case (n)
      1:       return 24'h010204;
      2:       return 24'h020408;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected gap: first pixel counted from busy rising (n+1), later pixels write-to-write (n+2).
  task automatic push_frame(input int n_tab[NPIX], input int npix);
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      e.row  = i / H;
      e.col  = i % H;
      e.data = colour_of(n_tab[i]);
      e.gap  = n_tab[i] + ((i == 0) ? 1 : 2);
      e.last = (i == NPIX - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st);
    @(negedge clock);
    start     = 1'b1;
    re_origin = re;
    im_origin = im;
    step      = st;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic wait_writes(input int target, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (wr_seen >= target) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: saw %0d writes, wanted %0d", wr_seen, target);
    end
  endtask

  // Monitor: pops the scoreboard on every write and checks the done pulse that follows the last one.
  initial begin
    int   cyc = 0;
    int   last_evt = 0;
    bit   busy_prev = 0;
    bit   pend_done = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        busy_prev = 0;
        pend_done = 0;
      end else begin
        if (done || pend_done) chk("done_pulse", done, pend_done);
        pend_done = 0;
        if (busy && !busy_prev) last_evt = cyc;
        busy_prev = busy;
        if (vram_wr_en) begin
          wr_seen++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: row %0d col %0d data %06h", vram_wr_row, vram_wr_col,
                     vram_wr_data);
          end else begin
            e = sb.pop_front();
            chk("wr_row", vram_wr_row, e.row);
            chk("wr_col", vram_wr_col, e.col);
            chk("wr_data", vram_wr_data, e.data);
            chk("wr_gap", cyc - last_evt, e.gap);
            chk("wr_busy", busy, 1);
            pend_done = e.last;
            last_evt  = cyc;
          end
        end
      end
    end
  end

  initial begin
    int base;
    n_zero = '{default: MAXI};
    n_one  = '{default: 1};
    // c = 1.5 + 0.25*col - 0.25i*row; (0,2) sits exactly on |c|^2 = 4 and must not escape.
    n_mix  = '{2, 2, 2, 1, 2, 2, 1, 1, 2, 2, 1, 1};

    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", vram_wr_en, 0);
    chk("rst_row", vram_wr_row, 0);
    chk("rst_col", vram_wr_col, 0);
    chk("rst_data", vram_wr_data, 0);
    reset_n = 1'b1;

    // Every c within a few LSBs of zero: all pixels hit MAX_ITER and write black.
    push_frame(n_zero, NPIX);
    pulse_start('0, '0, 32'd1);
    wait_done(NPIX * 300);
    chk("zero_busy_after_done", busy, 0);
    chk("zero_sb_empty", sb.size(), 0);

    // Escape on the second check everywhere; a mid-frame start toward c = 0 must be ignored.
    push_frame(n_one, NPIX);
    pulse_start(FX_2_5, '0, FX_0_25);
    repeat (8) @(negedge clock);
    pulse_start('0, '0, 32'd1);
    wait_done(300);
    chk("esc_sb_empty", sb.size(), 0);

    // Mixed counts that depend on cr rewinding per row and ci stepping downward.
    push_frame(n_mix, NPIX);
    pulse_start(FX_1_5, '0, FX_0_25);
    repeat (5) @(negedge clock);
    pulse_start(FX_2_5, 32'h0800_0000, FX_0_25);
    wait_done(300);
    chk("mix_sb_empty", sb.size(), 0);

    // Reset while pixel 5 is iterating: no more writes, outputs cleared at once.
    push_frame(n_zero, 5);
    base = wr_seen;
    pulse_start('0, '0, 32'd1);
    wait_writes(base + 5, 5 * 300);
    repeat (100) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wr_en", vram_wr_en, 0);
    chk("midrst_row", vram_wr_row, 0);
    chk("midrst_col", vram_wr_col, 0);
    chk("midrst_data", vram_wr_data, 0);
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (300) @(negedge clock);
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_sb_empty", sb.size(), 0);

    // Fresh frame after reset restarts at (0,0).
    push_frame(n_one, NPIX);
    pulse_start(FX_2_5, '0, FX_0_25);
    wait_done(300);
    repeat (3) @(negedge clock);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
